// File: rtl/sprite_renderer_pkg.sv
//==============================================================================
// Module   : sprite_renderer_pkg
// Brief    : Shared colours, sprite IDs and sprite geometry for the renderer.
// Revision : 1.0
//==============================================================================
`default_nettype none

package sprite_renderer_pkg;

  localparam logic [2:0] C_BLACK   = 3'b000;
  localparam logic [2:0] C_BLUE    = 3'b001;
  localparam logic [2:0] C_GREEN   = 3'b010;
  localparam logic [2:0] C_CYAN    = 3'b011;
  localparam logic [2:0] C_RED     = 3'b100;
  localparam logic [2:0] C_MAGENTA = 3'b101;
  localparam logic [2:0] C_YELLOW  = 3'b110;
  localparam logic [2:0] C_WHITE   = 3'b111;

  localparam int SPRITE_W  = 32;
  localparam int SPRITE_AW = $clog2(SPRITE_W);

  typedef enum logic [2:0] {
    INV_A   = 3'd0,
    INV_B   = 3'd1,
    SHIP    = 3'd2,
    BULLET  = 3'd3,
    EXPLODE = 3'd4
  } sprite_id_e;

endpackage

`default_nettype wire

// File: rtl/sprite_rom.sv
//==============================================================================
// Module   : sprite_rom
// Brief    : Combinational 32x32 one-bit sprite bitmaps, selected by sprite ID.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sprite_rom
  import sprite_renderer_pkg::*;
(
  input  sprite_id_e           id_i,
  input  logic [SPRITE_AW-1:0] row_i,
  input  logic [SPRITE_AW-1:0] col_i,
  output logic                 bit_o
);

  always_comb begin
    bit_o = 1'b0;
    case (id_i)
      INV_A:   bit_o = ~row_i[4];
      INV_B:   bit_o = row_i[4];
      // Ship: lower hull plus a central mast spanning columns 12..19
      SHIP:    bit_o = row_i[4] | (col_i[4:2] == 3'b011) | (col_i[4:2] == 3'b100);
      BULLET:  bit_o = (col_i >= 5'd14) && (col_i <= 5'd17);
      EXPLODE: bit_o = ~(row_i[2] ^ col_i[2]);
      default: bit_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sprite_renderer.sv
//==============================================================================
// Module   : sprite_renderer
// Brief    : Two-stage beam-position to RGB sprite renderer with animation,
//            explosions, multiple bullets and a checkerboard test pattern.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sprite_renderer
  import sprite_renderer_pkg::*;
#(
  parameter int TILE_LOG2      = 5,
  parameter int COLS           = 20,
  parameter int ROWS           = 2,
  parameter int N_BULLETS      = 2,
  parameter int SHIP_ROW       = 13,
  parameter int ANIM_FRAMES    = 30,
  parameter int EXPLODE_FRAMES = 15
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [9:0]             VGAx,
  input  logic [9:0]             VGAy,
  input  logic                   pix_valid,
  input  logic                   frame_start,
  input  logic                   test_mode,
  input  logic [ROWS*COLS-1:0]   invArray,
  input  logic [4:0]             invLine,
  input  logic [4:0]             shipX,
  input  logic [5*N_BULLETS-1:0] bulletX,
  input  logic [4*N_BULLETS-1:0] bulletY,
  input  logic [N_BULLETS-1:0]   bulletFlying,
  input  logic                   hit_valid,
  input  logic [4:0]             hit_x,
  input  logic [4:0]             hit_y,
  output logic [2:0]             rgb,
  output logic                   rgb_valid
);

  localparam int FCW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int ECW = $clog2(EXPLODE_FRAMES + 1);

  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           phase_q, phase_d;
  logic [ECW-1:0] exp_cnt_q, exp_cnt_d;
  logic [4:0]     hx_q, hx_d, hy_q, hy_d;

  // Game-state counters; stage 1 looks at the _d values so a pixel in the
  // frame_start cycle already sees the updated phase/explosion.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    exp_cnt_d   = exp_cnt_q;
    hx_d        = hx_q;
    hy_d        = hy_q;
    if (frame_start) begin
      if (frame_cnt_q == FCW'(ANIM_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
    if (hit_valid) begin
      exp_cnt_d = ECW'(EXPLODE_FRAMES);
      hx_d      = hit_x;
      hy_d      = hit_y;
    end else if (frame_start && (exp_cnt_q != '0)) begin
      exp_cnt_d = exp_cnt_q - ECW'(1);
    end
  end

  logic [9:0]           tx, ty;
  logic [SPRITE_AW-1:0] srow, scol;
  logic                 bul_m, ship_m, exp_m, inv_m, inv_odd;

  assign tx   = VGAx >> TILE_LOG2;
  assign ty   = VGAy >> TILE_LOG2;
  assign srow = SPRITE_AW'(VGAy[TILE_LOG2-1:0]) << (SPRITE_AW - TILE_LOG2);
  assign scol = SPRITE_AW'(VGAx[TILE_LOG2-1:0]) << (SPRITE_AW - TILE_LOG2);

  always_comb begin
    bul_m   = 1'b0;
    inv_m   = 1'b0;
    inv_odd = 1'b0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (bulletFlying[i] && (tx == {5'd0, bulletX[5*i +: 5]}) &&
          (ty == {6'd0, bulletY[4*i +: 4]}))
        bul_m = 1'b1;
    end
    ship_m = (tx == {5'd0, shipX}) && (ty == 10'(SHIP_ROW));
    exp_m  = (exp_cnt_d != '0) && (tx == {5'd0, hx_d}) && (ty == {5'd0, hy_d});
    // Exhaustive compare keeps every invArray index a constant in range.
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((ty == ({5'd0, invLine} + 10'(r))) && (tx == 10'(c))) begin
          inv_m   = invArray[r*COLS + c];
          inv_odd = r[0];
        end
      end
    end
  end

  logic                 s1_valid_q, s1_test_q, s1_check_q, s1_phase_q;
  logic                 s1_bul_q, s1_ship_q, s1_exp_q, s1_inv_q, s1_odd_q;
  logic [SPRITE_AW-1:0] s1_row_q, s1_col_q;
  logic [2:0]           rgb_q, rgb_d;
  logic                 rgb_valid_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
      exp_cnt_q   <= '0;
      hx_q        <= '0;
      hy_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_test_q   <= 1'b0;
      s1_check_q  <= 1'b0;
      s1_phase_q  <= 1'b0;
      s1_bul_q    <= 1'b0;
      s1_ship_q   <= 1'b0;
      s1_exp_q    <= 1'b0;
      s1_inv_q    <= 1'b0;
      s1_odd_q    <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      rgb_q       <= C_BLACK;
      rgb_valid_q <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      exp_cnt_q   <= exp_cnt_d;
      hx_q        <= hx_d;
      hy_q        <= hy_d;
      s1_valid_q  <= pix_valid;
      s1_test_q   <= test_mode;
      s1_check_q  <= tx[0] ^ ty[0];
      s1_phase_q  <= phase_d;
      s1_bul_q    <= bul_m;
      s1_ship_q   <= ship_m;
      s1_exp_q    <= exp_m;
      s1_inv_q    <= inv_m;
      s1_odd_q    <= inv_odd;
      s1_row_q    <= srow;
      s1_col_q    <= scol;
      rgb_q       <= rgb_d;
      rgb_valid_q <= s1_valid_q;
    end
  end

  sprite_id_e sid;
  logic       sbit;
  logic [2:0] obj_col;
  logic       obj_any;

  always_comb begin
    sid     = s1_phase_q ? INV_B : INV_A;
    obj_col = s1_odd_q ? C_GREEN : C_MAGENTA;
    obj_any = s1_bul_q | s1_ship_q | s1_exp_q | s1_inv_q;
    if (s1_bul_q) begin
      sid     = BULLET;
      obj_col = C_YELLOW;
    end else if (s1_ship_q) begin
      sid     = SHIP;
      obj_col = C_RED;
    end else if (s1_exp_q) begin
      sid     = EXPLODE;
      obj_col = C_WHITE;
    end
  end

  sprite_rom u_rom (
    .id_i  (sid),
    .row_i (s1_row_q),
    .col_i (s1_col_q),
    .bit_o (sbit)
  );

  always_comb begin
    rgb_d = C_BLACK;
    if (s1_valid_q) begin
      if (s1_test_q)
        rgb_d = s1_check_q ? C_WHITE : C_BLACK;
      else if (obj_any && sbit)
        rgb_d = obj_col;
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

`default_nettype wire
